a0_trace_fifo: RTL

A0_TRACE_FIFO -- requirements
Module: a0_trace_fifo

---
 rtl/a0_trace_fifo_if.sv | 27 ++
 rtl/a0_trace_fifo.sv | 86 ++++++++
 2 files changed

// File: rtl/a0_trace_fifo_if.sv
// Capture/consume bundle for the a0 trace FIFO; the FIFO sits on the slave side.
interface a0_trace_fifo_if #(
    parameter int DW    = 8,
    parameter int TW    = 16,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                 en_i;
    logic                 clr_i;
    logic [DW-1:0]        a0_i;
    logic [TW+DW-1:0]     dout_o;
    logic                 valid_o;
    logic                 ready_i;
    logic [CW-1:0]        count_o;
    logic                 overflow_o;

    modport master (
        output en_i, clr_i, a0_i, ready_i,
        input  dout_o, valid_o, count_o, overflow_o
    );

    modport slave (
        input  en_i, clr_i, a0_i, ready_i,
        output dout_o, valid_o, count_o, overflow_o
    );
endinterface

// File: rtl/a0_trace_fifo.sv
// Timestamped change-capture FIFO for the CPU a0 value; entries visible one cycle after capture.
// Pops on valid&ready; when full a lone capture is dropped and sets the sticky overflow flag.
module a0_trace_fifo #(
    parameter int DW    = 8,
    parameter int TW    = 16,
    parameter int DEPTH = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    a0_trace_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [TW-1:0]    tstamp;
    logic [DW-1:0]    prev;
    logic             primed;
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             overflow;
    logic [TW+DW-1:0] mem [DEPTH];

    logic capture, valid, pop, full, wr, drop;

    always_comb begin
        valid   = (count != '0);
        full    = (count == CW'(DEPTH));
        capture = bus.en_i && (!primed || (bus.a0_i != prev));
        pop     = valid && bus.ready_i;
        // A full FIFO still takes a capture if the head leaves in the same cycle.
        wr      = capture && (!full || pop);
        drop    = capture && full && !pop;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tstamp   <= '0;
            prev     <= '0;
            primed   <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (bus.clr_i) begin
            tstamp   <= '0;
            primed   <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            tstamp <= tstamp + 1'b1;
            if (bus.en_i) begin
                prev   <= bus.a0_i;
                primed <= 1'b1;
            end
            if (wr) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (wr && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !wr) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage is never reset; the output mux hides stale entries while empty.
    always_ff @(posedge clk_i) begin
        if (wr && !bus.clr_i) begin
            mem[wptr] <= {tstamp, bus.a0_i};
        end
    end

    assign bus.valid_o    = valid;
    assign bus.dout_o     = valid ? mem[rptr] : '0;
    assign bus.count_o    = count;
    assign bus.overflow_o = overflow;
endmodule
